// File: rtl/scytale_encryption_pkg.sv
// Shared Scytale definitions: start token, pad byte and the COLLECT/EMIT/DONE state encoding.
package scytale_encryption_pkg;

  localparam logic [7:0] SCYTALE_START_TOKEN = 8'hFA;
  localparam logic [7:0] SCYTALE_PAD_BYTE    = 8'h00;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DONE    = 2'd2
  } scytale_state_e;

endpackage

// File: rtl/scytale_encryption_index_gen.sv
// Column-major read index generator: row/column counters, strided address, last-element flag.
module scytale_index_gen #(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned AW        = 6
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic [KEY_WIDTH-1:0] n_i,
  input  logic [KEY_WIDTH-1:0] m_i,
  output logic [AW-1:0]        addr_o,
  output logic                 last_c_o
);

  logic [KEY_WIDTH-1:0] r_q, r_d;
  logic [KEY_WIDTH-1:0] c_q, c_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 row_wrap_c;

  assign row_wrap_c = (r_q == (m_i - KEY_WIDTH'(1)));
  assign last_c_o   = row_wrap_c && (c_q == (n_i - KEY_WIDTH'(1)));
  assign addr_o     = addr_q;

  // Stride by N down a column; on row wrap jump to the top of the next column.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    addr_d = addr_q;
    if (clear_i) begin
      r_d    = '0;
      c_d    = '0;
      addr_d = '0;
    end else if (step_i && !last_c_o) begin
      if (row_wrap_c) begin
        r_d    = '0;
        c_d    = c_q + KEY_WIDTH'(1);
        addr_d = AW'(c_q + KEY_WIDTH'(1));
      end else begin
        r_d    = r_q + KEY_WIDTH'(1);
        addr_d = addr_q + AW'(n_i);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale cipher encoder: buffers plaintext until the start token, then emits column-major ciphertext.
// Optional SCYTALE_ENC_PAD_EN: short messages are zero-padded instead of rejected.
module scytale_encryption
  import scytale_encryption_pkg::*;
#(
  parameter int unsigned        D_WIDTH                = 8,
  parameter int unsigned        KEY_WIDTH              = 8,
  parameter int unsigned        MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(SCYTALE_START_TOKEN)
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(MAX_NOF_CHARS);
  localparam int unsigned CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned PW = 2 * KEY_WIDTH;

  scytale_state_e       state_q, state_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [KEY_WIDTH-1:0] n_q, n_d, m_q, m_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];

  logic                 wr_en_c, step_c, clear_c, last_c, reject_c, len_bad_c;
  logic [AW-1:0]        rd_addr;
  logic [PW-1:0]        len_c;
  logic [D_WIDTH-1:0]   rd_data_c;

  scytale_index_gen #(
    .KEY_WIDTH (KEY_WIDTH),
    .AW        (AW)
  ) u_index_gen (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clear_i  (clear_c),
    .step_i   (step_c),
    .n_i      (n_q),
    .m_i      (m_q),
    .addr_o   (rd_addr),
    .last_c_o (last_c)
  );

  assign len_c = PW'(key_N) * PW'(key_M);

  // Length policy and read data depend on whether short messages are padded.
  always_comb begin
`ifdef SCYTALE_ENC_PAD_EN
    len_bad_c = PW'(wr_cnt_q) > len_c;
    rd_data_c = (CW'(rd_addr) < wr_cnt_q) ? buf_q[rd_addr] : D_WIDTH'(SCYTALE_PAD_BYTE);
`else
    len_bad_c = PW'(wr_cnt_q) != len_c;
    rd_data_c = buf_q[rd_addr];
`endif
  end

  assign reject_c = (key_N == '0) || (key_M == '0) ||
                    (len_c > PW'(MAX_NOF_CHARS)) || len_bad_c;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    n_d      = n_q;
    m_d      = m_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    wr_en_c  = 1'b0;
    step_c   = 1'b0;
    clear_c  = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (valid_i) begin
          if (data_i == START_ENCRYPTION_TOKEN) begin
            n_d     = key_N;
            m_d     = key_M;
            busy_d  = 1'b1;
            state_d = reject_c ? ST_DONE : ST_EMIT;
          end else if (wr_cnt_q != CW'(MAX_NOF_CHARS)) begin
            wr_en_c  = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      ST_EMIT: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        data_d  = rd_data_c;
        step_c  = 1'b1;
        if (last_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        clear_c  = 1'b1;
        wr_cnt_d = '0;
        state_d  = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_COLLECT;
      wr_cnt_q <= '0;
      n_q      <= '0;
      m_q      <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      n_q      <= n_d;
      m_q      <= m_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Message storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk_sys) begin
    if (wr_en_c) buf_q[AW'(wr_cnt_q)] <= data_i;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Randomized bench for scytale_encryption against a matrix-transpose reference model.
module tb_scytale_encryption;

  localparam int unsigned MAXC = 50;
  localparam logic [7:0]  TOK  = 8'hFA;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] data_i  = '0;
  logic       valid_i = 1'b0;
  logic [7:0] key_N   = '0;
  logic [7:0] key_M   = '0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  scytale_encryption dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] n, input logic [7:0] m);
    @(negedge clk_sys);
    valid_i = v;
    data_i  = d;
    key_N   = n;
    key_M   = m;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == TOK) b = b ^ 8'h01;
    return b;
  endfunction

  // Reference: store up to MAXC bytes, then read the N-wide row-major matrix column by column.
  task automatic model(input logic [7:0] pt[$], input int n, input int m,
                       output logic [7:0] exp[$], output bit rej);
    logic [7:0] st[$];
    int len;
    st = {};
    exp = {};
    foreach (pt[i]) if (st.size() < MAXC) st.push_back(pt[i]);
    len = n * m;
    rej = (n == 0) || (m == 0) || (len > MAXC);
`ifdef SCYTALE_ENC_PAD_EN
    if (st.size() > len) rej = 1'b1;
`else
    if (st.size() != len) rej = 1'b1;
`endif
    if (!rej)
      for (int c = 0; c < n; c++)
        for (int r = 0; r < m; r++)
          exp.push_back((r * n + c < st.size()) ? st[r * n + c] : 8'h00);
  endtask

  task automatic run_msg(input logic [7:0] pt[$], input logic [7:0] n, input logic [7:0] m,
                         input bit burst, input string tag);
    logic [7:0] exp[$];
    bit rej;
    int len;
    logic [7:0] d;
    model(pt, int'(n), int'(m), exp, rej);
    foreach (pt[i]) drive(1'b1, pt[i], 8'($urandom), 8'($urandom));
    drive(1'b1, TOK, n, m);
    @(posedge clk_sys); #1;
    check({tag, " busy_tok"}, 32'(busy), 32'd1);
    check({tag, " valid_tok"}, 32'(valid_o), 32'd0);
    len = rej ? 0 : exp.size();
    for (int i = 0; i <= len; i++) begin
      if (burst && ($urandom_range(1, 0) == 1)) begin
        d = ($urandom_range(3, 0) == 0) ? TOK : 8'($urandom);
        drive(1'b1, d, 8'($urandom_range(4, 1)), 8'($urandom_range(4, 1)));
      end else begin
        drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      @(posedge clk_sys); #1;
      if (i < len) begin
        check({tag, " valid"}, 32'(valid_o), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " data"}, 32'(data_o), 32'(exp[i]));
      end else begin
        check({tag, " valid_end"}, 32'(valid_o), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        if (len > 0) check({tag, " data_hold"}, 32'(data_o), 32'(exp[len - 1]));
      end
    end
    valid_i = 1'b0;
  endtask

  function automatic void str2q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
  endfunction

  initial begin
    logic [7:0] q[$];
    int n, m, len;

    #12;
    check("reset data_o", 32'(data_o), 32'd0);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    str2q("ABCDEF", q);      run_msg(q, 8'd3, 8'd2, 1'b0, "abcdef");
    str2q("HELLOWORLD", q);  run_msg(q, 8'd5, 8'd2, 1'b0, "hello");
    str2q("SECONDMSG", q);   run_msg(q, 8'd3, 8'd3, 1'b0, "back2back");
    str2q("BURSTYMESSAGE!", q); run_msg(q, 8'd7, 8'd2, 1'b1, "burst");
    str2q("ABC", q);         run_msg(q, 8'd0, 8'd3, 1'b0, "n_zero");
    q = {};
    for (int i = 0; i < 50; i++) q.push_back(rand_byte());
    run_msg(q, 8'd8, 8'd8, 1'b0, "n_m_64");
    str2q("ABCD", q);        run_msg(q, 8'd3, 8'd2, 1'b0, "short");
    q = {};
    for (int i = 0; i < 55; i++) q.push_back(rand_byte());
    run_msg(q, 8'd5, 8'd10, 1'b0, "saturate");
    str2q("Z", q);           run_msg(q, 8'd1, 8'd1, 1'b0, "single");

    // Asynchronous reset in the middle of emission.
    str2q("ABCDEF", q);
    foreach (q[i]) drive(1'b1, q[i], 8'd0, 8'd0);
    drive(1'b1, TOK, 8'd2, 8'd3);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    @(posedge clk_sys);
    @(posedge clk_sys); #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid data_o", 32'(data_o), 32'd0);
    check("rst_mid valid_o", 32'(valid_o), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    str2q("XY", q);          run_msg(q, 8'd2, 8'd1, 1'b0, "after_rst");

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(8, 1);
      m = $urandom_range(6, 1);
      len = ($urandom_range(3, 0) == 0) ? $urandom_range(50, 1) : n * m;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_byte());
      run_msg(q, 8'(n), 8'(m), bit'($urandom_range(1, 0)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
